// File: rtl/bus_bridge_m_uart_frame_ctrl_if.sv
// Purpose: bus-B request/response signals between the UART frame controller and the bus-B master.
// Latency: none, wires only.
// Backpressure: req_valid/req_ready for requests, resp_valid/resp_ready for responses.
//   master modport: the frame controller (issues requests, accepts responses)
//   slave modport : the bus-B master interface (accepts requests, returns responses)
interface bus_bridge_m_uart_frame_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_is_write;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_rdata;
    logic        resp_is_write;

    modport master (
        output req_valid, req_addr, req_wdata, req_is_write, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_is_write
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_is_write, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_is_write
    );
endinterface

// File: rtl/bus_bridge_m_uart_frame_ctrl.sv
// Purpose: deframe 4-byte UART requests into one bus-B request, serialise the 2-byte response back.
// Latency: req_valid rises the cycle after the flags byte is detected; one transaction in flight.
// Backpressure: request held stable until req_ready; TX bytes wait for uart_tx_busy low.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   uart_rx_data/_ready, uart_ready_clr received byte, held flag, release pulse
//   uart_tx_busy, uart_wr_en, uart_data_in transmitter handshake and byte
//   bus (master modport)               bus-B request/response channel
//   frame_err_cnt                      saturating count of discarded frames
//   busy                               high whenever a frame is being handled
module bus_bridge_m_uart_frame_ctrl #(
    parameter int CLK_FREQ_HZ       = 50000000,
    parameter int RX_TIMEOUT_CYCLES = 20000,
    parameter int ERR_CNT_W         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    uart_rx_data,
    input  logic                          uart_rx_ready,
    output logic                          uart_ready_clr,
    input  logic                          uart_tx_busy,
    output logic                          uart_wr_en,
    output logic [7:0]                    uart_data_in,
    bus_bridge_m_uart_frame_ctrl_if.master bus,
    output logic [ERR_CNT_W-1:0]          frame_err_cnt,
    output logic                          busy
);

    // The clock frequency only matters to whoever derives byte times; reject nonsense values.
    if (CLK_FREQ_HZ < 1 || RX_TIMEOUT_CYCLES < 2 || ERR_CNT_W < 1) begin : g_param_check
        $error("bus_bridge_m_uart_frame_ctrl: illegal parameter value");
    end

    localparam int TO_W = $clog2(RX_TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        RX_ADDR_L,
        RX_ADDR_H,
        RX_DATA,
        RX_FLAGS,
        REQ_ISSUE,
        WAIT_RESP,
        TX_RDATA,
        TX_WAIT_RDATA,
        TX_FLAGS,
        TX_WAIT_FLAGS
    } state_t;

    state_t          state_q, state_d;
    logic            rx_ready_q;
    logic            rx_pulse;
    logic [TO_W-1:0] to_cnt;
    logic            to_expired;
    logic            seen_busy_q;

    logic [7:0] addr_l_q, addr_h_q, wdata_q, rdata_q;
    logic       is_write_q, resp_wr_q;

    logic       ld_addr_l, ld_addr_h, ld_wdata, ld_flags, ld_resp;
    logic       err_inc, to_tick, tx_fire;
    logic [7:0] tx_byte;

    // A held rx byte is consumed once, on the cycle its ready level first appears.
    assign rx_pulse   = uart_rx_ready & ~rx_ready_q;
    assign to_expired = (to_cnt == TO_LAST) & ~rx_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_ADDR_L;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_addr_l = 1'b0;
        ld_addr_h = 1'b0;
        ld_wdata  = 1'b0;
        ld_flags  = 1'b0;
        ld_resp   = 1'b0;
        err_inc   = 1'b0;
        to_tick   = 1'b0;
        tx_fire   = 1'b0;
        tx_byte   = 8'h00;
        unique case (state_q)
            RX_ADDR_L: begin
                if (rx_pulse) begin
                    ld_addr_l = 1'b1;
                    state_d   = RX_ADDR_H;
                end
            end
            RX_ADDR_H: begin
                to_tick = 1'b1;
                if (rx_pulse) begin
                    ld_addr_h = 1'b1;
                    state_d   = RX_DATA;
                end else if (to_expired) begin
                    err_inc = 1'b1;
                    state_d = RX_ADDR_L;
                end
            end
            RX_DATA: begin
                to_tick = 1'b1;
                if (rx_pulse) begin
                    ld_wdata = 1'b1;
                    state_d  = RX_FLAGS;
                end else if (to_expired) begin
                    err_inc = 1'b1;
                    state_d = RX_ADDR_L;
                end
            end
            RX_FLAGS: begin
                to_tick = 1'b1;
                if (rx_pulse) begin
                    // Only bit0 carries meaning; anything else marks a corrupt frame.
                    if (|uart_rx_data[7:1]) begin
                        err_inc = 1'b1;
                        state_d = RX_ADDR_L;
                    end else begin
                        ld_flags = 1'b1;
                        state_d  = REQ_ISSUE;
                    end
                end else if (to_expired) begin
                    err_inc = 1'b1;
                    state_d = RX_ADDR_L;
                end
            end
            REQ_ISSUE: begin
                if (bus.req_ready) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (bus.resp_valid) begin
                    ld_resp = 1'b1;
                    state_d = TX_RDATA;
                end
            end
            TX_RDATA: begin
                if (!uart_tx_busy) begin
                    tx_fire = 1'b1;
                    tx_byte = rdata_q;
                    state_d = TX_WAIT_RDATA;
                end
            end
            TX_WAIT_RDATA: begin
                // Busy may rise late after wr_en; wait for a full busy high->low.
                if (seen_busy_q && !uart_tx_busy) state_d = TX_FLAGS;
            end
            TX_FLAGS: begin
                if (!uart_tx_busy) begin
                    tx_fire = 1'b1;
                    tx_byte = {7'b0, resp_wr_q};
                    state_d = TX_WAIT_FLAGS;
                end
            end
            TX_WAIT_FLAGS: begin
                if (seen_busy_q && !uart_tx_busy) state_d = RX_ADDR_L;
            end
            default: state_d = RX_ADDR_L;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q     <= 1'b0;
            uart_ready_clr <= 1'b0;
            to_cnt         <= '0;
            seen_busy_q    <= 1'b0;
            addr_l_q       <= 8'h00;
            addr_h_q       <= 8'h00;
            wdata_q        <= 8'h00;
            is_write_q     <= 1'b0;
            rdata_q        <= 8'h00;
            resp_wr_q      <= 1'b0;
            uart_wr_en     <= 1'b0;
            uart_data_in   <= 8'h00;
            frame_err_cnt  <= '0;
        end else begin
            rx_ready_q     <= uart_rx_ready;
            // Release every detected byte, even ones dropped outside the RX states.
            uart_ready_clr <= rx_pulse;

            // Counting only while mid-frame also clears it on the way into RX_ADDR_L.
            if (to_tick && !rx_pulse && !to_expired) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (ld_addr_l) addr_l_q   <= uart_rx_data;
            if (ld_addr_h) addr_h_q   <= uart_rx_data;
            if (ld_wdata)  wdata_q    <= uart_rx_data;
            if (ld_flags)  is_write_q <= uart_rx_data[0];
            if (ld_resp) begin
                rdata_q   <= bus.resp_rdata;
                resp_wr_q <= bus.resp_is_write;
            end

            if (tx_fire) begin
                seen_busy_q <= 1'b0;
            end else if ((state_q == TX_WAIT_RDATA || state_q == TX_WAIT_FLAGS) && uart_tx_busy) begin
                seen_busy_q <= 1'b1;
            end

            uart_wr_en <= tx_fire;
            if (tx_fire) uart_data_in <= tx_byte;

            if (err_inc && !(&frame_err_cnt)) frame_err_cnt <= frame_err_cnt + 1'b1;
        end
    end

    assign bus.req_valid    = (state_q == REQ_ISSUE);
    assign bus.req_addr     = {addr_h_q, addr_l_q};
    assign bus.req_wdata    = wdata_q;
    assign bus.req_is_write = is_write_q;
    assign bus.resp_ready   = (state_q == WAIT_RESP);
    assign busy             = (state_q != RX_ADDR_L);

endmodule
